nn_forward_sequencer: RTL and testbench
=======================================

# nn_forward_sequencer

Sequences one forward pass of the two-layer fully-connected digit classifier over a single shared multiply-accumulate datapath. It streams pixels and weights from external synchronous memories, applies bias, ReLU and scaling, and holds hidden activations internally. The final argmax becomes the predicted digit. It sits under the master controller: the controller raises `start`/`en`, waits for `done`, and samples `predicted_digit`.

## Interface
- `N_INPUT`, 196: input pixels (14x14 downsampled frame)
- `N_HIDDEN`, 32: hidden-layer neurons
- `N_OUTPUT`, 10: output neurons (digits 0..9, must be ≤16)
- `DATA_W`, 16: signed fixed-point width of pixels, weights, biases and activations
- `FRAC`, 8: fractional bits of the DATA_W format
- `ACC_W`, 40: signed accumulator width
- `clk` in 1: system clock
- `reset` in 1: one clock; reset is synchronous and active-low
- `en` in 1: clock enable; low freezes all state, counters and outputs
- `start` in 1: level; sampled only in IDLE
- `busy` out 1: high in every state except IDLE and DONE
- `done` out 1: one-cycle pulse; `predicted_digit` is valid in that cycle
- `predicted_digit` out 4: argmax of the last completed pass, held until the next DONE
- `pixel_addr` out clog2(N_INPUT): pixel memory read address
- `pixel_data` in DATA_W: pixel for the address of the previous clk edge (1-cycle latency)
- `weight_addr` out clog2(W_DEPTH): weight/bias ROM address
- `weight_data` in DATA_W: signed ROM word (1-cycle latency)

## Operation
- ROM layout, W_DEPTH = N_HIDDEN·(N_INPUT+1) + N_OUTPUT·(N_HIDDEN+1):
  - L1 neuron j, input i: j·(N_INPUT+1)+i; its bias is at i=N_INPUT.
  - L2 base L2_BASE = N_HIDDEN·(N_INPUT+1); neuron k, input i: L2_BASE+k·(N_HIDDEN+1)+i; its bias is at i=N_HIDDEN.
- States: IDLE, L1_MAC, L1_BIAS, L1_WRITE, L2_MAC, L2_BIAS, L2_CMP, DONE.
  - IDLE: go to L1_MAC if `start`; clear the neuron counter and the accumulator.
  - L1_MAC / L2_MAC: issue input i and weight i, for i = 0..N_in−1, one per cycle. Each cycle also accumulates the product returned for the previous address.
  - L1_BIAS / L2_BIAS: issue the bias address; accumulate the last product.
  - L1_WRITE: compute acc + (bias<<<FRAC), then >>>FRAC, then ReLU (negative becomes 0), then saturate to +(2^(DATA_W−1)−1). Write the result to hidden[j] and clear the accumulator. Next state is L1_MAC for j+1, or L2_MAC after j=N_HIDDEN−1.
  - L2_MAC reads hidden[i] through a registered read, so it has the same 1-cycle latency as the memories.
  - L2_CMP: score = (acc + (bias<<<FRAC))>>>FRAC, kept at ACC_W with no ReLU. Replace the best score and index only if the score is strictly greater, so ties resolve to the lowest index. Neuron 0 always loads. Next state is L2_MAC for k+1, or DONE after k=N_OUTPUT−1.
  - DONE: load `predicted_digit` and pulse `done`; return to IDLE. If `start` is still high, a new pass begins on the next IDLE cycle.
- Products: DATA_W×DATA_W signed gives a 2·DATA_W result, sign-extended to ACC_W. The accumulator wraps; there is no saturation before the finish step.
- `start` outside IDLE is ignored.
- Reset mid-pass: return to IDLE with the accumulator cleared. No `done` pulse is emitted for the aborted pass.

## Timing
- Reset values: `busy`=0, `done`=0, `predicted_digit`=0, `pixel_addr`=0, `weight_addr`=0, state IDLE, hidden buffer don't-care.
- If `start` is sampled high in IDLE at enabled cycle t:
  - L1 occupies t+1 .. t+L1, with L1 = N_HIDDEN·(N_INPUT+2).
  - L2 occupies the next L2 = N_OUTPUT·(N_HIDDEN+2) cycles.
  - `done` is high at enabled cycle t+L1+L2+1. With defaults that is t+6677.
- `en` low: addresses are held, so memory data remains that of the held address. No accumulate, write or transition occurs. Latency extends by exactly the number of disabled cycles.

## Structure
- Package `nn_pkg`: default sizes, the state encoding localparams, W_DEPTH/L2_BASE constants and the address-computation function.
- Sub-module `nn_mac_unit`: multiply, accumulate, clear, bias-align, shift, ReLU/saturate.
- The FSM, counters, hidden buffer and argmax stay in the top module.

## Test plan
- Reset held 3 cycles, then released with `start`=0: all outputs at reset values, `busy`=0 indefinitely.
- All weights 0, output bias 7 = 0x0100, others 0; `start` pulse: `done` at t+6677, `predicted_digit`=7, `busy` low after.
- All weights and biases 0: every score is 0 (tie) → `predicted_digit`=0.
- Hidden bias −1.0, all L1 weights 0, L2 weights 1.0 for output 3 only, output biases 0: all hidden values clamp to 0, all scores tie at 0 → digit 0. Then set hidden bias to +1.0 → digit 3.
- `en` low for 50 cycles inside L1_MAC at neuron 5: `done` at t+6727, same digit as the undisturbed run.
- `reset` low for 1 cycle during L2_MAC: state IDLE, no `done`. A following `start` gives a correct full pass with standard latency. `start` held high continuously produces back-to-back passes, with `done` pulses 6678 cycles apart.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared sizing, state encoding and ROM address helper for the digit-classifier forward pass.
package nn_pkg;

  // Default network dimensions and number formats
  localparam int NN_N_INPUT  = 196;
  localparam int NN_N_HIDDEN = 32;
  localparam int NN_N_OUTPUT = 10;
  localparam int NN_DATA_W   = 16;
  localparam int NN_FRAC     = 8;
  localparam int NN_ACC_W    = 40;

  // Weight/bias ROM geometry for the default sizes
  localparam int NN_L2_BASE  = NN_N_HIDDEN * (NN_N_INPUT + 1);
  localparam int NN_W_DEPTH  = NN_L2_BASE + NN_N_OUTPUT * (NN_N_HIDDEN + 1);

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_L1_MAC   = 3'd1,
    ST_L1_BIAS  = 3'd2,
    ST_L1_WRITE = 3'd3,
    ST_L2_MAC   = 3'd4,
    ST_L2_BIAS  = 3'd5,
    ST_L2_CMP   = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  // ROM word address of input idx of a neuron; each neuron row holds n_in weights then its bias
  function automatic int unsigned rom_addr(input int unsigned base,
                                           input int unsigned neuron,
                                           input int unsigned n_in,
                                           input int unsigned idx);
    return base + neuron * (n_in + 32'd1) + idx;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Signed multiply-accumulate with bias alignment, rescale and ReLU/saturate finish step.
module nn_mac_unit #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     accumulate,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [ACC_W-1:0]  score,
  output logic        [DATA_W-1:0] activation
);

  localparam logic signed [ACC_W-1:0] ACT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  logic signed [2*DATA_W-1:0] product_s;
  logic signed [ACC_W-1:0]    product_ext_s;
  logic signed [ACC_W-1:0]    bias_ext_s;
  logic signed [ACC_W-1:0]    sum_s;
  logic signed [ACC_W-1:0]    acc_r;

  // Full-precision product, sign-extended to the accumulator width
  always_comb begin
    product_s     = op_a * op_b;
    product_ext_s = {{(ACC_W-2*DATA_W){product_s[2*DATA_W-1]}}, product_s};
  end

  // Accumulator: clear has priority, otherwise wraps freely on accumulate
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en) begin
      if (clear) begin
        acc_r <= {ACC_W{1'b0}};
      end else if (accumulate) begin
        acc_r <= acc_r + product_ext_s;
      end
    end
  end

  // Finish: align bias to the product scale, drop FRAC bits, then clamp to [0, max positive]
  always_comb begin
    bias_ext_s = {{(ACC_W-DATA_W-FRAC){bias[DATA_W-1]}}, bias, {FRAC{1'b0}}};
    sum_s      = acc_r + bias_ext_s;
    score      = sum_s >>> FRAC;
    if (score[ACC_W-1]) begin
      activation = {DATA_W{1'b0}};
    end else if (score > ACT_MAX) begin
      activation = ACT_MAX[DATA_W-1:0];
    end else begin
      activation = score[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/nn_forward_sequencer.sv
// Two-layer fully-connected forward pass over one shared MAC, with internal hidden buffer and argmax.
module nn_forward_sequencer
  import nn_pkg::*;
#(
  parameter int N_INPUT  = NN_N_INPUT,
  parameter int N_HIDDEN = NN_N_HIDDEN,
  parameter int N_OUTPUT = NN_N_OUTPUT,
  parameter int DATA_W   = NN_DATA_W,
  parameter int FRAC     = NN_FRAC,
  parameter int ACC_W    = NN_ACC_W,
  localparam int PAW     = $clog2(N_INPUT),
  localparam int WAW     = $clog2(N_HIDDEN * (N_INPUT + 1) + N_OUTPUT * (N_HIDDEN + 1))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        predicted_digit,
  output logic [PAW-1:0]    pixel_addr,
  input  logic [DATA_W-1:0] pixel_data,
  output logic [WAW-1:0]    weight_addr,
  input  logic [DATA_W-1:0] weight_data
);

  // Input counter spans the wider of the two layers (the pixel layer); neuron counter spans the hidden layer
  localparam int CW = $clog2(N_INPUT);
  localparam int NW = $clog2(N_HIDDEN);
  localparam int unsigned L2_BASE = N_HIDDEN * (N_INPUT + 1);

  localparam logic [CW-1:0] L1_IN_LAST  = CW'(N_INPUT - 1);
  localparam logic [CW-1:0] L2_IN_LAST  = CW'(N_HIDDEN - 1);
  localparam logic [NW-1:0] HID_LAST    = NW'(N_HIDDEN - 1);
  localparam logic [NW-1:0] OUT_LAST    = NW'(N_OUTPUT - 1);

  state_t                    state_r;
  logic [CW-1:0]             in_cnt_r;
  logic [NW-1:0]             neuron_r;
  logic [NW-1:0]             hid_addr_r;
  logic [PAW-1:0]            pixel_addr_r;
  logic [WAW-1:0]            weight_addr_r;
  logic                      busy_r;
  logic                      done_r;
  logic [3:0]                digit_r;
  logic signed [ACC_W-1:0]   best_score_r;
  logic [3:0]                best_idx_r;

  logic [DATA_W-1:0]         hidden_mem_r [N_HIDDEN];
  logic [DATA_W-1:0]         hidden_q_r;

  logic                      mac_clear_s;
  logic                      mac_acc_s;
  logic [DATA_W-1:0]         op_a_s;
  logic signed [ACC_W-1:0]   mac_score_s;
  logic [DATA_W-1:0]         mac_act_s;
  logic                      take_best_s;

  // Datapath control: the product of the address issued last cycle lands this cycle
  always_comb begin
    mac_clear_s = 1'b0;
    mac_acc_s   = 1'b0;
    op_a_s      = pixel_data;
    case (state_r)
      ST_L1_MAC: begin
        mac_acc_s = (in_cnt_r != {CW{1'b0}});
      end
      ST_L1_BIAS: begin
        mac_acc_s = 1'b1;
      end
      ST_L2_MAC: begin
        mac_acc_s = (in_cnt_r != {CW{1'b0}});
        op_a_s    = hidden_q_r;
      end
      ST_L2_BIAS: begin
        mac_acc_s = 1'b1;
        op_a_s    = hidden_q_r;
      end
      ST_IDLE, ST_L1_WRITE, ST_L2_CMP, ST_DONE: begin
        mac_clear_s = 1'b1;
      end
      default: begin
        mac_clear_s = 1'b1;
      end
    endcase
  end

  // Argmax update: neuron 0 always loads, later neurons only on a strictly greater score
  always_comb begin
    take_best_s = (neuron_r == {NW{1'b0}}) || (mac_score_s > best_score_r);
  end

  nn_mac_unit #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clear      (mac_clear_s),
    .accumulate (mac_acc_s),
    .op_a       (op_a_s),
    .op_b       (weight_data),
    .bias       (weight_data),
    .score      (mac_score_s),
    .activation (mac_act_s)
  );

  // Hidden buffer: written once per L1 neuron, read through a register to mirror memory latency
  always_ff @(posedge clk) begin
    if (reset && en) begin
      if (state_r == ST_L1_WRITE) begin
        hidden_mem_r[neuron_r] <= mac_act_s;
      end
      hidden_q_r <= hidden_mem_r[hid_addr_r];
    end
  end

  // Sequencer FSM with counters, address generation, argmax and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      in_cnt_r      <= {CW{1'b0}};
      neuron_r      <= {NW{1'b0}};
      hid_addr_r    <= {NW{1'b0}};
      pixel_addr_r  <= {PAW{1'b0}};
      weight_addr_r <= {WAW{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      digit_r       <= 4'd0;
      best_score_r  <= {ACC_W{1'b0}};
      best_idx_r    <= 4'd0;
    end else if (en) begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r       <= ST_L1_MAC;
            busy_r        <= 1'b1;
            neuron_r      <= {NW{1'b0}};
            in_cnt_r      <= {CW{1'b0}};
            pixel_addr_r  <= {PAW{1'b0}};
            weight_addr_r <= WAW'(rom_addr(32'd0, 32'd0, N_INPUT, 32'd0));
          end
        end
        ST_L1_MAC: begin
          weight_addr_r <= weight_addr_r + {{(WAW-1){1'b0}}, 1'b1};
          if (in_cnt_r == L1_IN_LAST) begin
            state_r <= ST_L1_BIAS;
          end else begin
            in_cnt_r     <= in_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            pixel_addr_r <= pixel_addr_r + {{(PAW-1){1'b0}}, 1'b1};
          end
        end
        ST_L1_BIAS: begin
          state_r <= ST_L1_WRITE;
        end
        ST_L1_WRITE: begin
          in_cnt_r <= {CW{1'b0}};
          if (neuron_r == HID_LAST) begin
            state_r       <= ST_L2_MAC;
            neuron_r      <= {NW{1'b0}};
            hid_addr_r    <= {NW{1'b0}};
            weight_addr_r <= WAW'(rom_addr(L2_BASE, 32'd0, N_HIDDEN, 32'd0));
          end else begin
            state_r       <= ST_L1_MAC;
            neuron_r      <= neuron_r + {{(NW-1){1'b0}}, 1'b1};
            pixel_addr_r  <= {PAW{1'b0}};
            weight_addr_r <= WAW'(rom_addr(32'd0, 32'(neuron_r) + 32'd1, N_INPUT, 32'd0));
          end
        end
        ST_L2_MAC: begin
          weight_addr_r <= weight_addr_r + {{(WAW-1){1'b0}}, 1'b1};
          if (in_cnt_r == L2_IN_LAST) begin
            state_r <= ST_L2_BIAS;
          end else begin
            in_cnt_r   <= in_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            hid_addr_r <= hid_addr_r + {{(NW-1){1'b0}}, 1'b1};
          end
        end
        ST_L2_BIAS: begin
          state_r <= ST_L2_CMP;
        end
        ST_L2_CMP: begin
          in_cnt_r <= {CW{1'b0}};
          if (take_best_s) begin
            best_score_r <= mac_score_s;
            best_idx_r   <= 4'(neuron_r);
          end
          if (neuron_r == OUT_LAST) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            digit_r  <= take_best_s ? 4'(neuron_r) : best_idx_r;
            neuron_r <= {NW{1'b0}};
          end else begin
            state_r       <= ST_L2_MAC;
            neuron_r      <= neuron_r + {{(NW-1){1'b0}}, 1'b1};
            hid_addr_r    <= {NW{1'b0}};
            weight_addr_r <= WAW'(rom_addr(L2_BASE, 32'(neuron_r) + 32'd1, N_HIDDEN, 32'd0));
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign predicted_digit = digit_r;
  assign pixel_addr      = pixel_addr_r;
  assign weight_addr     = weight_addr_r;

endmodule

// File: tb/tb_nn_forward_sequencer.sv
// Randomized self-checking bench: memory models plus an arithmetic reference of the forward pass.
module tb_nn_forward_sequencer;
  import nn_pkg::*;

  localparam int NI   = NN_N_INPUT;
  localparam int NH   = NN_N_HIDDEN;
  localparam int NO   = NN_N_OUTPUT;
  localparam int L2B  = NN_L2_BASE;
  localparam int WD   = NN_W_DEPTH;
  localparam int LAT  = NH * (NI + 2) + NO * (NH + 2) + 1;

  logic        clk;
  logic        reset;
  logic        en;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  predicted_digit;
  logic [7:0]  pixel_addr;
  logic [15:0] pixel_data;
  logic [12:0] weight_addr;
  logic [15:0] weight_data;

  logic signed [15:0] pix_mem [NI];
  logic signed [15:0] rom     [WD];

  int n_checks;
  int n_errors;

  nn_forward_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .predicted_digit (predicted_digit),
    .pixel_addr      (pixel_addr),
    .pixel_data      (pixel_data),
    .weight_addr     (weight_addr),
    .weight_data     (weight_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read pixel memory and weight ROM, one cycle of latency
  always @(posedge clk) begin
    pixel_data  <= pix_mem[pixel_addr];
    weight_data <= rom[weight_addr];
  end

  task automatic check_eq(input string tag, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Reference forward pass from the arithmetic rules: floor rescale, ReLU, saturate, first-max argmax
  function automatic int ref_digit();
    longint hid [NH];
    longint acc, v, best;
    int     bi;
    best = 0;
    bi   = 0;
    for (int j = 0; j < NH; j++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) acc += longint'(pix_mem[i]) * longint'(rom[j*(NI+1)+i]);
      v = (acc + longint'(rom[j*(NI+1)+NI]) * 64'sd256) >>> 8;
      if (v < 0) v = 0;
      if (v > 32767) v = 32767;
      hid[j] = v;
    end
    for (int k = 0; k < NO; k++) begin
      acc = 0;
      for (int i = 0; i < NH; i++) acc += hid[i] * longint'(rom[L2B+k*(NH+1)+i]);
      v = (acc + longint'(rom[L2B+k*(NH+1)+NH]) * 64'sd256) >>> 8;
      if (k == 0 || v > best) begin
        best = v;
        bi   = k;
      end
    end
    return bi;
  endfunction

  task automatic fill_zero();
    for (int i = 0; i < NI; i++) pix_mem[i] = 16'sd0;
    for (int i = 0; i < WD; i++) rom[i] = 16'sd0;
  endtask

  task automatic fill_random(input int span);
    for (int i = 0; i < NI; i++) pix_mem[i] = 16'(int'($urandom_range(0, 2*span-1)) - span);
    for (int i = 0; i < WD; i++) rom[i] = 16'(int'($urandom_range(0, 2*span-1)) - span);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One pass from a start pulse; optional en-low window of gap_len edges starting at cycle gap_at
  task automatic run_pass(input string tag, input int gap_at, input int gap_len,
                          input int exp_lat, input int exp_digit);
    int   cyc;
    int   done_cyc;
    logic busy_mid;
    done_cyc = -1;
    busy_mid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (done_cyc < 0 && cyc < exp_lat + 200) begin
      if (cyc == 2) busy_mid = busy;
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (cyc == gap_at) en = 1'b0;
        if (cyc == gap_at + gap_len) en = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    en = 1'b1;
    check_eq({tag, "_busy_mid"}, busy_mid, 1);
    check_eq({tag, "_latency"}, done_cyc, exp_lat);
    check_eq({tag, "_digit"}, predicted_digit, exp_digit);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_digit_held"}, predicted_digit, exp_digit);
  endtask

  initial begin
    int cyc;
    int d1;
    int d2;
    int dig1;
    int dig2;
    int exp_d;
    int busy_seen;
    int done_seen;

    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    en       = 1'b1;
    start    = 1'b0;
    fill_zero();

    // Reset state and quiet idle
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_digit", predicted_digit, 0);
    check_eq("rst_pixel_addr", pixel_addr, 0);
    check_eq("rst_weight_addr", weight_addr, 0);
    reset = 1'b1;
    busy_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy || done) busy_seen++;
    end
    check_eq("idle_quiet", busy_seen, 0);

    // Output bias 7 = 1.0 wins over all-zero scores
    fill_zero();
    rom[L2B + 7*(NH+1) + NH] = 16'sh0100;
    run_pass("bias7", -1, 0, LAT, 7);

    // Everything zero: all scores tie, lowest index wins
    fill_zero();
    run_pass("allzero", -1, 0, LAT, 0);

    // Negative hidden bias clamps hidden to 0; positive hidden bias lets output 3 win
    fill_zero();
    for (int j = 0; j < NH; j++) rom[j*(NI+1) + NI] = 16'shFF00;
    for (int i = 0; i < NH; i++) rom[L2B + 3*(NH+1) + i] = 16'sh0100;
    run_pass("relu_clamp", -1, 0, LAT, 0);
    for (int j = 0; j < NH; j++) rom[j*(NI+1) + NI] = 16'sh0100;
    run_pass("relu_pass", -1, 0, LAT, 3);

    // Random network, undisturbed then with en low for 50 cycles inside neuron 5
    fill_random(64);
    exp_d = ref_digit();
    run_pass("rand_small", -1, 0, LAT, exp_d);
    run_pass("en_gap", 1000, 50, LAT + 50, exp_d);

    // Reset pulse during L2_MAC aborts the pass with no done
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6399) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_weight_addr", weight_addr, 0);
    done_seen = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check_eq("midrst_no_done", done_seen, 0);

    // Full-range random values exercise saturation and wide accumulation
    fill_random(32768);
    exp_d = ref_digit();
    run_pass("rand_full", -1, 0, LAT, exp_d);

    // start held high: back-to-back passes
    fill_random(48);
    exp_d = ref_digit();
    d1 = -1;
    d2 = -1;
    dig1 = -1;
    dig2 = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1;
    while (d2 < 0 && cyc < 2*(LAT+1) + 100) begin
      if (done) begin
        if (d1 < 0) begin
          d1   = cyc;
          dig1 = predicted_digit;
        end else begin
          d2   = cyc;
          dig2 = predicted_digit;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check_eq("b2b_first_latency", d1, LAT);
    check_eq("b2b_spacing", d2 - d1, LAT + 1);
    check_eq("b2b_digit1", dig1, exp_d);
    check_eq("b2b_digit2", dig2, exp_d);
    apply_reset(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
